// File: rtl/gpu_pkg.sv
// Shared definitions for the fragment pipeline: screen limits, depth constants,
// fragment record layout (also decoded by the z-buffer consumer) and span FSM states.
package gpu_pkg;

    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // 16'hFFFF is the cleared z-buffer value, so emitted depths stop one short of it.
    localparam logic [15:0] Z_CLEAR = 16'hFFFF;
    localparam logic [15:0] Z_MAX   = 16'hFFFE;

    localparam int FR_W     = 16;
    localparam int FR_X_LSB = 240;
    localparam int FR_Y_LSB = 224;
    localparam int FR_Z_LSB = 208;
    localparam int FR_R_LSB = 48;
    localparam int FR_G_LSB = 32;
    localparam int FR_B_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EMIT
    } span_state_t;

    function automatic logic [15:0] sat_depth(input logic signed [31:0] acc);
        if (acc < 32'sd0)
            return 16'd0;
        else if (acc > 32'sd65534)
            return Z_MAX;
        else
            return acc[15:0];
    endfunction

endpackage

// File: rtl/z_interp.sv
// Depth interpolator: loads z0 + offset*dz for the first visible pixel, then
// advances by dz per emitted pixel and presents the saturated depth.
module z_interp
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] z0,
    input  logic [15:0] dz,
    input  logic [16:0] offset,
    output logic [15:0] sat_z
);

    logic signed [31:0] r_acc;
    logic signed [31:0] w_dz_ext;
    logic signed [31:0] w_prod;
    logic signed [31:0] w_load_val;

    // offset is the count of pixels clipped off the left edge, always non-negative.
    assign w_dz_ext   = $signed({{16{dz[15]}}, dz});
    assign w_prod     = $signed({15'd0, offset}) * w_dz_ext;
    assign w_load_val = $signed({16'd0, z0}) + w_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= 32'sd0;
        else if (load)
            r_acc <= w_load_val;
        else if (step)
            r_acc <= r_acc + w_dz_ext;
    end

    assign sat_z = sat_depth(r_acc);

endmodule

// File: rtl/span_rasterizer.sv
// Span rasterizer: clips one horizontal span to the screen and pushes one
// fragment record per pixel into the z-buffer queue, throttled by queue occupancy.
module span_rasterizer
    import gpu_pkg::*;
#(
    parameter logic [15:0] QUEUE_DEPTH = 16'd64,
    parameter int          SCREEN_W    = SCREEN_W_DEF,
    parameter int          SCREEN_H    = SCREEN_H_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         span_valid,
    output logic         span_ready,
    input  logic [15:0]  span_y,
    input  logic [15:0]  span_x0,
    input  logic [15:0]  span_x1,
    input  logic [15:0]  span_z0,
    input  logic [15:0]  span_dz,
    input  logic [7:0]   span_r,
    input  logic [7:0]   span_g,
    input  logic [7:0]   span_b,
    output logic         z_adding,
    output logic [255:0] z_add_regs,
    input  logic [15:0]  z_size,
    output logic         busy,
    output logic [31:0]  frag_count
);

    localparam logic signed [15:0] X_MAX = $signed(16'(SCREEN_W - 1));
    localparam logic signed [15:0] Y_MAX = $signed(16'(SCREEN_H - 1));

    span_state_t r_state;
    span_state_t w_next;

    logic signed [15:0] r_y;
    logic signed [15:0] r_x0;
    logic signed [15:0] r_x1;
    logic [15:0]        r_z0;
    logic [15:0]        r_dz;
    logic [7:0]         r_r;
    logic [7:0]         r_g;
    logic [7:0]         r_b;

    logic signed [15:0] r_x;
    logic signed [15:0] r_xe;
    logic               r_adding;
    logic [255:0]       r_rec;
    logic [31:0]        r_frag_count;

    logic               w_accept;
    logic               w_load;
    logic               w_push;
    logic               w_empty;
    logic               w_credit;
    logic               w_last;
    logic signed [15:0] w_xs;
    logic signed [15:0] w_xe;
    logic [16:0]        w_offset;
    logic [15:0]        w_sat_z;
    logic [255:0]       w_record;

    // Span clipping, evaluated on the latched fields during SETUP.
    assign w_empty = (r_y < 16'sd0) || (r_y > Y_MAX) || (r_x0 > r_x1) ||
                     (r_x1 < 16'sd0) || (r_x0 > X_MAX);
    assign w_xs     = (r_x0 < 16'sd0) ? 16'sd0 : r_x0;
    assign w_xe     = (r_x1 > X_MAX) ? X_MAX : r_x1;
    assign w_offset = {w_xs[15], w_xs} - {r_x0[15], r_x0};

    // A push still in flight is not yet visible in z_size, so it is counted here.
    assign w_credit = ({1'b0, z_size} + {16'd0, r_adding}) < {1'b0, QUEUE_DEPTH};
    assign w_last   = (r_x == r_xe);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (span_valid) w_next = ST_SETUP;
            ST_SETUP: w_next = w_empty ? ST_IDLE : ST_EMIT;
            ST_EMIT:  if (w_push && w_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        span_ready = (r_state == ST_IDLE);
        busy       = (r_state != ST_IDLE);
        w_accept   = (r_state == ST_IDLE) && span_valid;
        w_load     = (r_state == ST_SETUP) && !w_empty;
        w_push     = (r_state == ST_EMIT) && w_credit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y  <= 16'sd0;
            r_x0 <= 16'sd0;
            r_x1 <= 16'sd0;
            r_z0 <= 16'd0;
            r_dz <= 16'd0;
            r_r  <= 8'd0;
            r_g  <= 8'd0;
            r_b  <= 8'd0;
        end else if (w_accept) begin
            r_y  <= span_y;
            r_x0 <= span_x0;
            r_x1 <= span_x1;
            r_z0 <= span_z0;
            r_dz <= span_dz;
            r_r  <= span_r;
            r_g  <= span_g;
            r_b  <= span_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x  <= 16'sd0;
            r_xe <= 16'sd0;
        end else if (w_load) begin
            r_x  <= w_xs;
            r_xe <= w_xe;
        end else if (w_push) begin
            r_x  <= r_x + 16'sd1;
        end
    end

    z_interp u_z_interp (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .step   (w_push),
        .z0     (r_z0),
        .dz     (r_dz),
        .offset (w_offset),
        .sat_z  (w_sat_z)
    );

    always_comb begin
        w_record                      = '0;
        w_record[FR_X_LSB +: FR_W]    = r_x;
        w_record[FR_Y_LSB +: FR_W]    = r_y;
        w_record[FR_Z_LSB +: FR_W]    = w_sat_z;
        w_record[FR_R_LSB +: FR_W]    = {8'h00, r_r};
        w_record[FR_G_LSB +: FR_W]    = {8'h00, r_g};
        w_record[FR_B_LSB +: FR_W]    = {8'h00, r_b};
    end

    // The record register only loads on a push, so it holds across stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adding     <= 1'b0;
            r_rec        <= '0;
            r_frag_count <= 32'd0;
        end else begin
            r_adding <= w_push;
            if (w_push) begin
                r_rec        <= w_record;
                r_frag_count <= r_frag_count + 32'd1;
            end
        end
    end

    assign z_adding   = r_adding;
    assign z_add_regs = r_rec;
    assign frag_count = r_frag_count;

endmodule
